// File: rtl/xfer_counter.sv
// xfer_counter -- byte/bit transfer counter for the I2C master.
//
// Tracks the bit slot inside each byte frame (BYTE_BITS data slots plus one
// ACK slot) and the number of bytes still to transfer. Early-warning flags
// let the master controller schedule NACK/STOP ahead of the final byte.
//
// Handshake: load, abort and bit_tick are single-cycle strobes with no ready
// path; the counter accepts every strobe on the edge it is sampled. When
// several arrive together only the highest priority one acts
// (abort > load > bit_tick) and the others are dropped.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   load          latch packet_length, clear bit position, enter DATA
//   packet_length bytes to transfer (0 means 2^BITS)
//   bit_tick      one SCL bit slot completed
//   abort         drop the transfer, return to IDLE
//   remaining     bytes not yet completed
//   bit_index     current slot; 0..BYTE_BITS-1 data, BYTE_BITS is ACK
//   ack_phase     in the ACK slot
//   byte_done     registered pulse when an ACK slot completes
//   xfer_done     registered pulse when remaining goes 1 -> 0
//   last_byte     remaining == 1
//   near_end      1 <= remaining <= LOOKAHEAD
//   zero          remaining == 0
//   busy          not IDLE
//   overrun       sticky: bit_tick seen while IDLE; cleared by load/abort
//   state_dbg     raw FSM state (0 IDLE, 1 DATA, 2 ACK) for checkers
module xfer_counter #(
    parameter int BITS      = 6,
    parameter int BYTE_BITS = 8,
    parameter int LOOKAHEAD = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           load,
    input  logic [BITS-1:0]                packet_length,
    input  logic                           bit_tick,
    input  logic                           abort,
    output logic [BITS:0]                  remaining,
    output logic [$clog2(BYTE_BITS+1)-1:0] bit_index,
    output logic                           ack_phase,
    output logic                           byte_done,
    output logic                           xfer_done,
    output logic                           last_byte,
    output logic                           near_end,
    output logic                           zero,
    output logic                           busy,
    output logic                           overrun,
    output logic [1:0]                     state_dbg
);

    localparam int IW = $clog2(BYTE_BITS + 1);
    localparam logic [IW-1:0]  LAST_DATA = IW'(BYTE_BITS - 1);
    localparam logic [IW-1:0]  ACK_IDX   = IW'(BYTE_BITS);
    localparam logic [BITS:0]  FULL_LEN  = {1'b1, {BITS{1'b0}}};
    localparam logic [BITS:0]  LOOK      = (BITS+1)'(LOOKAHEAD);
    localparam logic [BITS:0]  ONE       = (BITS+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [BITS:0] rem_q, rem_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          byte_done_d, xfer_done_d, overrun_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rem_q     <= '0;
            idx_q     <= '0;
            byte_done <= 1'b0;
            xfer_done <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            idx_q     <= idx_d;
            byte_done <= byte_done_d;
            xfer_done <= xfer_done_d;
            overrun   <= overrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        idx_d       = idx_q;
        byte_done_d = 1'b0;
        xfer_done_d = 1'b0;
        overrun_d   = overrun;

        if (abort) begin
            state_d   = S_IDLE;
            rem_d     = '0;
            idx_d     = '0;
            overrun_d = 1'b0;
        end else if (load) begin
            // A load while busy is a repeated start: the old count is discarded.
            rem_d     = (packet_length == '0) ? FULL_LEN : {1'b0, packet_length};
            idx_d     = '0;
            state_d   = S_DATA;
            overrun_d = 1'b0;
        end else if (bit_tick) begin
            case (state_q)
                S_IDLE: begin
                    overrun_d = 1'b1;
                end
                S_DATA: begin
                    if (idx_q == LAST_DATA) begin
                        idx_d   = ACK_IDX;
                        state_d = S_ACK;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                S_ACK: begin
                    // ACK is only entered with rem_q >= 1, so this cannot wrap.
                    rem_d       = rem_q - ONE;
                    idx_d       = '0;
                    byte_done_d = 1'b1;
                    if (rem_q == ONE) begin
                        xfer_done_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign remaining = rem_q;
    assign bit_index = idx_q;
    assign ack_phase = (state_q == S_ACK);
    assign busy      = (state_q != S_IDLE);
    assign zero      = (rem_q == '0);
    assign last_byte = (rem_q == ONE);
    assign near_end  = (rem_q != '0) && (rem_q <= LOOK);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_xfer_counter.sv
module tb_xfer_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       load, bit_tick, abort;
    logic [5:0] packet_length;

    logic [6:0] remaining;
    logic [3:0] bit_index;
    logic       ack_phase, byte_done, xfer_done, last_byte, near_end, zero, busy, overrun;
    logic [1:0] state_dbg;

    // second instance with LOOKAHEAD=2, same stimulus; only near_end is of interest
    logic [6:0] remaining2;
    logic [3:0] bit_index2;
    logic       ack_phase2, byte_done2, xfer_done2, last_byte2, near_end2, zero2, busy2, overrun2;
    logic [1:0] state_dbg2;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    xfer_counter #(.BITS(6), .BYTE_BITS(8), .LOOKAHEAD(1)) dut (
        .clk(clk), .rst(rst), .load(load), .packet_length(packet_length),
        .bit_tick(bit_tick), .abort(abort), .remaining(remaining),
        .bit_index(bit_index), .ack_phase(ack_phase), .byte_done(byte_done),
        .xfer_done(xfer_done), .last_byte(last_byte), .near_end(near_end),
        .zero(zero), .busy(busy), .overrun(overrun), .state_dbg(state_dbg)
    );

    xfer_counter #(.BITS(6), .BYTE_BITS(8), .LOOKAHEAD(2)) dut2 (
        .clk(clk), .rst(rst), .load(load), .packet_length(packet_length),
        .bit_tick(bit_tick), .abort(abort), .remaining(remaining2),
        .bit_index(bit_index2), .ack_phase(ack_phase2), .byte_done(byte_done2),
        .xfer_done(xfer_done2), .last_byte(last_byte2), .near_end(near_end2),
        .zero(zero2), .busy(busy2), .overrun(overrun2), .state_dbg(state_dbg2)
    );

    // ---------------- reference model ----------------
    // Transfer described as "len bytes, m_ticks bit slots consumed so far";
    // position and remaining count follow by division by the frame length.
    localparam int FRAME = 9;
    bit m_busy, m_ovr, m_bd, m_xd;
    int m_len, m_ticks;

    task automatic model_reset();
        m_busy = 0; m_ovr = 0; m_bd = 0; m_xd = 0; m_len = 0; m_ticks = 0;
    endtask

    task automatic model_update(input bit a, input bit l, input int p, input bit t);
        m_bd = 0; m_xd = 0;
        if (a) begin
            m_busy = 0; m_len = 0; m_ticks = 0; m_ovr = 0;
        end else if (l) begin
            m_busy = 1; m_len = (p == 0) ? 64 : p; m_ticks = 0; m_ovr = 0;
        end else if (t) begin
            if (!m_busy) m_ovr = 1;
            else begin
                m_ticks++;
                if (m_ticks % FRAME == 0) begin
                    m_bd = 1;
                    if (m_ticks / FRAME == m_len) begin
                        m_xd = 1; m_busy = 0; m_len = 0; m_ticks = 0;
                    end
                end
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [19:0] exp_q[$];

    function automatic logic [19:0] got_bundle();
        return {remaining, bit_index, ack_phase, byte_done, xfer_done,
                last_byte, near_end, zero, busy, overrun, near_end2};
    endfunction

    task automatic check_all(input string name);
        int rem;
        logic [19:0] e, g;
        rem = m_len - m_ticks / FRAME;
        e = {7'(rem), 4'(m_ticks % FRAME), m_busy && (m_ticks % FRAME == 8),
             m_bd, m_xd, rem == 1, rem >= 1 && rem <= 1, rem == 0, m_busy,
             m_ovr, rem >= 1 && rem <= 2};
        exp_q.push_back(e);
        g = got_bundle();
        e = exp_q.pop_front();
        n_vec++;
        if (g !== e) begin
            n_err++;
            $display("FAIL %s: got %05h want %05h (rem,idx,ack,bd,xd,last,near,zero,busy,ovr,near2)",
                     name, g, e);
        end
    endtask

    task automatic expect_bit(input string name, input logic got, input logic want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0b want %0b", name, got, want);
        end
    endtask

    // ---------------- driver ----------------
    // Inputs are applied 1 time unit after an edge, outputs checked 1 unit
    // after the following edge.
    task automatic step(input bit a, input bit l, input logic [5:0] p, input bit t,
                        input string name);
        abort = a; load = l; packet_length = p; bit_tick = t;
        @(posedge clk);
        model_update(a, l, int'(p), t);
        #1;
        abort = 0; load = 0; bit_tick = 0;
        check_all(name);
    endtask

    task automatic ticks(input int n, input string name);
        for (int i = 0; i < n; i++) step(0, 0, 6'd0, 1, name);
    endtask

    typedef struct {
        bit a, l, t;
        logic [5:0] p;
        logic [6:0] rem;
        logic [3:0] idx;
        logic bd, xd, bsy, ovr;
    } vec_t;

    vec_t tbl[19];
    int xd_count;

    initial begin
        rst = 1; load = 0; bit_tick = 0; abort = 0; packet_length = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset_state");
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;

        // ---- table-driven vectors from reset ----
        tbl[0] = '{0,0,1, 6'd0, 7'd0,  4'd0, 0,0,0,1};
        tbl[1] = '{0,0,0, 6'd0, 7'd0,  4'd0, 0,0,0,1};
        tbl[2] = '{0,1,0, 6'd2, 7'd2,  4'd0, 0,0,1,0};
        tbl[3] = '{0,1,1, 6'd3, 7'd3,  4'd0, 0,0,1,0};
        tbl[4] = '{0,0,1, 6'd0, 7'd3,  4'd1, 0,0,1,0};
        tbl[5] = '{1,1,1, 6'd5, 7'd0,  4'd0, 0,0,0,0};
        tbl[6] = '{0,1,0, 6'd0, 7'd64, 4'd0, 0,0,1,0};
        tbl[7] = '{1,0,0, 6'd0, 7'd0,  4'd0, 0,0,0,0};
        tbl[8] = '{0,1,0, 6'd1, 7'd1,  4'd0, 0,0,1,0};
        for (int i = 9; i <= 16; i++) tbl[i] = '{0,0,1, 6'd0, 7'd1, 4'(i-8), 0,0,1,0};
        tbl[17] = '{0,0,1, 6'd0, 7'd0, 4'd0, 1,1,0,0};
        tbl[18] = '{0,0,0, 6'd0, 7'd0, 4'd0, 0,0,0,0};
        for (int i = 0; i < 19; i++) begin
            step(tbl[i].a, tbl[i].l, tbl[i].p, tbl[i].t, $sformatf("tbl_model[%0d]", i));
            n_vec++;
            if ({remaining, bit_index, byte_done, xfer_done, busy, overrun} !==
                {tbl[i].rem, tbl[i].idx, tbl[i].bd, tbl[i].xd, tbl[i].bsy, tbl[i].ovr}) begin
                n_err++;
                $display("FAIL tbl[%0d]: got rem=%0d idx=%0d bd=%0b xd=%0b busy=%0b ovr=%0b want rem=%0d idx=%0d bd=%0b xd=%0b busy=%0b ovr=%0b",
                         i, remaining, bit_index, byte_done, xfer_done, busy, overrun,
                         tbl[i].rem, tbl[i].idx, tbl[i].bd, tbl[i].xd, tbl[i].bsy, tbl[i].ovr);
            end
        end

        // ---- load 3, 27 ticks ----
        step(0, 1, 6'd3, 0, "load3");
        ticks(18, "len3_ticks");
        expect_bit("len3_last_byte", last_byte, 1'b1);
        ticks(9, "len3_tail");
        expect_bit("len3_xfer_done", xfer_done, 1'b1);
        step(0, 0, 6'd0, 0, "len3_idle");
        expect_bit("len3_xd_one_cycle", xfer_done, 1'b0);

        // ---- length 0 means 64 bytes, exactly one xfer_done ----
        step(0, 1, 6'd0, 0, "load64");
        xd_count = 0;
        for (int i = 0; i < 64 * 9; i++) begin
            step(0, 0, 6'd0, 1, "len64_ticks");
            if (xfer_done === 1'b1) xd_count++;
        end
        step(0, 0, 6'd0, 0, "len64_after");
        n_vec++;
        if (xd_count != 1) begin
            n_err++;
            $display("FAIL len64_xfer_count: got %0d want 1", xd_count);
        end

        // ---- LOOKAHEAD=2 with length 4 ----
        step(0, 1, 6'd4, 0, "load4");
        ticks(17, "len4_pre");
        expect_bit("len4_near2_before", near_end2, 1'b0);
        ticks(1, "len4_second_byte");
        expect_bit("len4_near2_after", near_end2, 1'b1);
        ticks(18, "len4_tail");

        // ---- reload at bit 5 of byte 2, then abort ----
        step(0, 1, 6'd3, 0, "load3b");
        ticks(9 + 5, "to_byte2_bit5");
        step(0, 1, 6'd2, 0, "reload2");
        ticks(9 * 2, "reload_run");
        step(1, 0, 6'd0, 0, "abort_idle");

        // ---- overrun held until load ----
        step(0, 0, 6'd0, 1, "idle_tick");
        step(0, 0, 6'd0, 0, "ovr_hold1");
        step(0, 0, 6'd0, 0, "ovr_hold2");
        step(0, 1, 6'd2, 0, "ovr_clear_load");

        // ---- async reset mid-frame, then load 1 + 9 ticks ----
        step(0, 1, 6'd1, 0, "load1_pre_rst");
        ticks(4, "to_bit4");
        #2;
        rst = 1;
        #1;
        model_reset();
        check_all("async_reset");
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;
        step(0, 1, 6'd1, 0, "load1_post_rst");
        ticks(9, "len1_ticks");
        expect_bit("len1_byte_done", byte_done, 1'b1);
        expect_bit("len1_xfer_done", xfer_done, 1'b1);

        // ---- randomized stimulus against the model ----
        for (int i = 0; i < 3000; i++) begin
            bit a, l, t;
            logic [5:0] p;
            a = ($urandom_range(0, 31) == 0);
            l = ($urandom_range(0, 15) == 0);
            t = ($urandom_range(0, 3) != 0);
            p = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(1, 4));
            step(a, l, p, t, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/xfer_counter.md
# xfer_counter

Parametrised byte/bit transfer counter for the I2C master, the successor to the single byte down-counter. It tracks the bit position within each byte frame (data bits plus ACK slot) and the number of bytes remaining. It raises early-warning flags so the master controller can schedule the NACK/STOP ahead of the final byte. It sits between the master FSM, which supplies bit ticks and load/abort strobes, and the shift register / ACK logic that consume its flags.

## Interface
Parameters:
- BITS, 6: packet-length field width; a programmed length of 0 means 2^BITS bytes.
- BYTE_BITS, 8: data bits per byte frame; each frame is BYTE_BITS + 1 ticks (data plus ACK).
- LOOKAHEAD, 1: near_end asserts when 1 <= remaining <= LOOKAHEAD; legal range 1..2^BITS.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- load  in  1  strobe: latch packet_length, clear bit position, enter DATA.
- packet_length  in  BITS  bytes to transfer (0 = 2^BITS).
- bit_tick  in  1  one SCL bit slot completed; single-cycle strobe.
- abort  in  1  strobe: drop the transfer and return to IDLE.
- remaining  out  BITS+1  bytes not yet completed.
- bit_index  out  $clog2(BYTE_BITS+1)  current slot in frame; 0..BYTE_BITS-1 are data, BYTE_BITS is ACK.
- ack_phase  out  1  high while in ACK state (bit_index == BYTE_BITS).
- byte_done  out  1  one-cycle pulse, registered, when an ACK slot completes.
- xfer_done  out  1  one-cycle pulse, registered, when remaining goes 1 -> 0.
- last_byte  out  1  remaining == 1.
- near_end  out  1  1 <= remaining <= LOOKAHEAD.
- zero  out  1  remaining == 0.
- busy  out  1  state != IDLE.
- overrun  out  1  sticky: bit_tick received while IDLE; cleared by load or abort.

## Operation
- States: IDLE, DATA, ACK.
- Event priority each cycle: abort > load > bit_tick. A lower-priority strobe in the same cycle is ignored entirely.
- abort: in any state, go to IDLE with remaining = 0 and bit_index = 0; clear overrun; no pulses.
- load: in any state, remaining = (packet_length == 0) ? 2^BITS : {1'b0, packet_length}; bit_index = 0; go to DATA; clear overrun. A load in DATA or ACK is a repeated-start reload and discards the old count without pulses.
- DATA + bit_tick:
  - bit_index < BYTE_BITS-1: bit_index increments.
  - bit_index == BYTE_BITS-1: bit_index = BYTE_BITS; go to ACK.
- ACK + bit_tick:
  - remaining decrements by 1, bit_index = 0, byte_done pulses.
  - If the new remaining is 0, xfer_done also pulses and the state goes to IDLE; otherwise it goes to DATA.
- IDLE + bit_tick: set overrun; nothing else changes.
- remaining never wraps. It is only decremented from ACK, and ACK is reachable only with remaining >= 1.
- Flags last_byte, near_end, zero and ack_phase decode combinationally from registered state; byte_done and xfer_done are registered.

## Timing
- Reset values: state IDLE, remaining 0, bit_index 0, ack_phase 0, byte_done 0, xfer_done 0, last_byte 0, near_end 0, zero 1, busy 0, overrun 0.
- load at edge N: remaining, busy and flags are valid in cycle N+1.
- The ACK-slot tick sampled at edge N gives byte_done = 1, the decremented remaining and bit_index = 0 all in cycle N+1; the pulse lasts exactly 1 cycle.
- xfer_done is coincident with the final byte_done; zero = 1 and busy = 0 in the same cycle.
- Back-to-back bit_tick on consecutive cycles is supported; every tick is counted.
- An asynchronous rst mid-frame forces the reset values immediately, independent of clk.

## Test plan
- BITS=6, BYTE_BITS=8: load 3, then 27 ticks. Required: byte_done after ticks 9, 18 and 27; remaining 3→2→1→0; last_byte high from after tick 18; xfer_done with tick 27; busy low afterwards.
- load with packet_length = 0 → remaining = 64, zero = 0, near_end = 0 (LOOKAHEAD=1); 64×9 ticks → exactly one xfer_done.
- LOOKAHEAD=2, load 4: near_end rises after the 2nd byte_done (remaining = 2) and stays high until zero.
- Same-cycle strobes, checked separately:
  - load + bit_tick → remaining = new length, bit_index = 0.
  - abort + load → IDLE, remaining = 0.
  - A reload at bit 5 of byte 2 restarts cleanly with no pulses.
- bit_tick while IDLE → overrun = 1 and held until the next load, which clears it.
- Assert rst at bit 4 of the ACK-pending byte → all outputs take their reset values immediately; a following load 1 plus 9 ticks → byte_done and xfer_done pulse together.
